mc_residual_stream: RTL and testbench
=====================================

MC_RESIDUAL_STREAM -- requirements
Module: mc_residual_stream

Interface
REQ-001 Parameter MB_W, default 8, block width in pixels.
REQ-002 Parameter MB_H, default 8, block height in pixels.
REQ-003 Parameter PIXEL_WIDTH, default 8, unsigned sample width.
REQ-004 Parameter PPC, default 2, pixels per beat; MB_W % PPC == 0 required, else elaboration error.
REQ-005 Derived: BEATS = MB_W*MB_H/PPC; RW = PIXEL_WIDTH+1; SAD_W = PIXEL_WIDTH+$clog2(MB_W*MB_H).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 src_valid  in  1  input beat valid.
REQ-009 src_ready  out  1  input beat accepted when src_valid & src_ready.
REQ-010 curr_pix  in  PPC*PIXEL_WIDTH  current-block lane k at [k*PIXEL_WIDTH +: PIXEL_WIDTH], raster order.
REQ-011 ref_pix  in  PPC*PIXEL_WIDTH  reference (predicted) pixels, same lane layout.
REQ-012 mode  in  1  0 = inter (curr-ref), 1 = intra-bypass (curr - 2^(PIXEL_WIDTH-1)); sampled on a block's first beat only.
REQ-013 flush  in  1  synchronous abort of current block.
REQ-014 dst_valid  out  1  output beat valid.
REQ-015 dst_ready  in  1  downstream accept.
REQ-016 residual_out  out  PPC*RW  signed two's-complement residual, lane k at [k*RW +: RW].
REQ-017 dst_first  out  1  high on beat 0 of a block.
REQ-018 dst_last  out  1  high on beat BEATS-1 of a block.
REQ-019 block_sad  out  SAD_W  sum of |residual| over whole block; meaningful only when dst_valid & dst_last.

Function
REQ-020 States: IDLE (beat_cnt==0, no block open) and ACTIVE (1 <= beat accepted < BEATS); IDLE->ACTIVE on first accepted beat, ACTIVE->IDLE on accepting beat BEATS-1 or on flush.
REQ-021 src_ready SHALL equal !dst_valid | dst_ready (single output register, combinational ready, no bubble at full throughput).
REQ-022 An accepted beat SHALL appear on residual_out exactly one cycle later with dst_valid=1; sustained throughput one beat per cycle.
REQ-023 dst_valid, residual_out, flags and block_sad SHALL hold stable while dst_valid & !dst_ready.
REQ-024 Each lane residual SHALL be computed at RW bits with sign extension: range -(2^PIXEL_WIDTH-1)..+(2^PIXEL_WIDTH-1); no wrap, no saturation.
REQ-025 mode latched on beat 0 SHALL apply to all beats of that block; mode changes mid-block ignored; in intra-bypass ref_pix ignored.
REQ-026 beat_cnt SHALL increment per accepted beat and wrap BEATS-1 -> 0; next block may start on the cycle after the last beat is accepted.
REQ-027 SAD accumulator SHALL clear on beat 0 (loaded with that beat's lane |residual| sum) and add each subsequent beat; block_sad on the last beat includes that beat; accumulator never overflows at SAD_W.
REQ-028 flush SHALL clear beat_cnt, SAD accumulator, latched mode and dst_valid next cycle; src_ready=0 during the flush cycle; an input beat presented with flush is discarded; flush has priority over all other events.
REQ-029 Simultaneous last-beat output handshake and next-block first-beat input acceptance SHALL both take effect in the same cycle.

Reset
REQ-030 While reset=1: dst_valid=0, dst_first=0, dst_last=0, residual_out=0, block_sad=0, beat_cnt=0, state IDLE, latched mode=0; src_ready=0.
REQ-031 Reset mid-block SHALL discard the partial block; first beat after reset release is beat 0.

Verification
REQ-032 Default params, mode=0, curr all 200, ref all 50, dst_ready=1 -> 32 beats, residual lanes +150, dst_first on beat 0, dst_last on beat 31, block_sad=9600.
REQ-033 mode=0, curr=0, ref=255 -> residual -255 (9'h101) every lane, block_sad=16320; curr=255, ref=0 -> +255, no wrap.
REQ-034 mode=1 on beat 0, curr=128, ref random, mode toggled mid-block -> all residuals 0, block_sad=0.
REQ-035 dst_ready toggled pseudo-randomly 50% -> no beat lost or duplicated, outputs stable while stalled, src_ready tracks REQ-021.
REQ-036 flush asserted at beat 10, then full block curr=10, ref=3 -> dst_valid low after flush, new block starts at beat 0, block_sad=448.
REQ-037 Back-to-back two blocks with dst_ready=1 -> 64 consecutive valid cycles, dst_last at cycles 32 and 64, dst_first at 1 and 33.

Source files
------------

// File: rtl/mc_residual_stream_if.sv
// Stream bundle for the motion-compensation residual stage: pixel beats in, residual beats out.
// The design end uses the slave modport and the driving end uses the master modport.
interface mc_residual_stream_if #(
  parameter int MB_W        = 8,
  parameter int MB_H        = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int PPC         = 2
);
  localparam int RW    = PIXEL_WIDTH + 1;
  localparam int SAD_W = PIXEL_WIDTH + $clog2(MB_W * MB_H);

  logic                         src_valid;
  logic                         src_ready;
  logic [PPC*PIXEL_WIDTH-1:0]   curr_pix;
  logic [PPC*PIXEL_WIDTH-1:0]   ref_pix;
  logic                         mode;
  logic                         flush;
  logic                         dst_valid;
  logic                         dst_ready;
  logic [PPC*RW-1:0]            residual_out;
  logic                         dst_first;
  logic                         dst_last;
  logic [SAD_W-1:0]             block_sad;

  modport master (
    output src_valid, curr_pix, ref_pix, mode, flush, dst_ready,
    input  src_ready, dst_valid, residual_out, dst_first, dst_last, block_sad
  );

  modport slave (
    input  src_valid, curr_pix, ref_pix, mode, flush, dst_ready,
    output src_ready, dst_valid, residual_out, dst_first, dst_last, block_sad
  );
endinterface

// File: rtl/mc_residual_stream.sv
// Per-pixel residual (curr - ref, or curr - mid-grey in intra bypass) over a macroblock stream,
// with a single output register stage and a running sum of absolute residuals per block.
module mc_residual_stream #(
  parameter int MB_W        = 8,
  parameter int MB_H        = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int PPC         = 2
) (
  input  logic                clk,
  input  logic                reset,
  mc_residual_stream_if.slave bus
);
  localparam int BEATS = MB_W * MB_H / PPC;
  localparam int RW    = PIXEL_WIDTH + 1;
  localparam int SAD_W = PIXEL_WIDTH + $clog2(MB_W * MB_H);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(BEATS - 1);
  localparam logic [RW-1:0]    INTRA_OFFSET = RW'(1) << (PIXEL_WIDTH - 1);

  generate
    if (MB_W % PPC != 0) begin : g_bad_ppc
      $error("mc_residual_stream: MB_W must be a multiple of PPC");
    end
  endgenerate

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               mode_q;
  logic               accept;
  logic               first_beat;
  logic               last_beat;
  logic               eff_mode;
  logic [RW-1:0]      lane_sub;
  logic [RW-1:0]      lane_res;
  logic [RW-1:0]      lane_mag;
  logic [PPC*RW-1:0]  residual_d;
  logic [SAD_W-1:0]   beat_sum;
  logic [SAD_W-1:0]   sad_d;
  logic [SAD_W-1:0]   sad_q;
  logic               dst_valid_q;
  logic               dst_first_q;
  logic               dst_last_q;
  logic [PPC*RW-1:0]  residual_q;

  // Ready looks only at the output register, so a full pipe still moves one beat per cycle.
  assign bus.src_ready = !reset && !bus.flush && (!dst_valid_q || bus.dst_ready);
  assign accept        = bus.src_valid && bus.src_ready;
  assign first_beat    = (state_q == IDLE);
  assign last_beat     = (beat_cnt_q == LAST_BEAT);
  assign eff_mode      = first_beat ? bus.mode : mode_q;

  always_comb begin
    residual_d = '0;
    beat_sum   = '0;
    lane_sub   = '0;
    lane_res   = '0;
    lane_mag   = '0;
    for (int k = 0; k < PPC; k++) begin
      lane_sub = eff_mode ? INTRA_OFFSET : {1'b0, bus.ref_pix[k*PIXEL_WIDTH +: PIXEL_WIDTH]};
      lane_res = {1'b0, bus.curr_pix[k*PIXEL_WIDTH +: PIXEL_WIDTH]} - lane_sub;
      lane_mag = lane_res[RW-1] ? (~lane_res + RW'(1)) : lane_res;
      residual_d[k*RW +: RW] = lane_res;
      beat_sum = beat_sum + SAD_W'(lane_mag);
    end
    sad_d = first_beat ? beat_sum : (sad_q + beat_sum);
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (bus.flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = ACTIVE;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Output stage only loads on an accepted beat, so everything holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_valid_q <= 1'b0;
      dst_first_q <= 1'b0;
      dst_last_q  <= 1'b0;
      residual_q  <= '0;
      sad_q       <= '0;
      mode_q      <= 1'b0;
    end else if (bus.flush) begin
      dst_valid_q <= 1'b0;
      sad_q       <= '0;
      mode_q      <= 1'b0;
    end else if (accept) begin
      dst_valid_q <= 1'b1;
      dst_first_q <= first_beat;
      dst_last_q  <= last_beat;
      residual_q  <= residual_d;
      sad_q       <= sad_d;
      if (first_beat) begin
        mode_q <= bus.mode;
      end
    end else if (bus.dst_ready) begin
      dst_valid_q <= 1'b0;
    end
  end

  assign bus.dst_valid    = dst_valid_q;
  assign bus.dst_first    = dst_first_q;
  assign bus.dst_last     = dst_last_q;
  assign bus.residual_out = residual_q;
  assign bus.block_sad    = sad_q;
endmodule

// File: tb/tb_mc_residual_stream.sv
// Bench for mc_residual_stream: directed and random beats compared every cycle
// against an integer model of the block residual / SAD rules.
module tb_mc_residual_stream;
  localparam int MB_W  = 8;
  localparam int MB_H  = 8;
  localparam int PW    = 8;
  localparam int PPC   = 2;
  localparam int RW    = PW + 1;
  localparam int BEATS = MB_W * MB_H / PPC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_residual_stream_if #(.MB_W(MB_W), .MB_H(MB_H), .PIXEL_WIDTH(PW), .PPC(PPC)) bus ();

  mc_residual_stream #(.MB_W(MB_W), .MB_H(MB_H), .PIXEL_WIDTH(PW), .PPC(PPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit exp_ready;
  bit exp_valid;
  bit exp_first;
  bit exp_last;
  logic [PPC*RW-1:0] exp_res;
  int exp_sad;
  int blk_beat;
  int blk_sad;
  bit blk_mode;
  bit model_rst;
  int valid_cycles;
  int obs_last_sad;
  logic [PPC*RW-1:0] obs_last_res;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [PPC*PW-1:0] fill(input int v);
    logic [PPC*PW-1:0] r;
    for (int k = 0; k < PPC; k++) r[k*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [PPC*PW-1:0] randPix();
    logic [PPC*PW-1:0] r;
    for (int k = 0; k < PPC; k++) r[k*PW +: PW] = PW'($urandom);
    return r;
  endfunction

  function automatic int laneResidual(input int c, input int r, input bit m);
    return m ? (c - (1 << (PW - 1))) : (c - r);
  endfunction

  task automatic checkOutput();
    checkVal("dst_valid", {31'd0, bus.dst_valid}, {31'd0, exp_valid});
    if (bus.dst_valid) valid_cycles++;
    if (exp_valid || model_rst) begin
      checkVal("residual_out", 32'(bus.residual_out), 32'(exp_res));
      checkVal("dst_first", {31'd0, bus.dst_first}, {31'd0, exp_first});
      checkVal("dst_last", {31'd0, bus.dst_last}, {31'd0, exp_last});
    end
    if ((exp_valid && exp_last) || model_rst)
      checkVal("block_sad", 32'(bus.block_sad), exp_sad);
    if (bus.dst_valid && bus.dst_last) begin
      obs_last_sad = int'(bus.block_sad);
      obs_last_res = bus.residual_out;
    end
  endtask

  // One clock: drive at the falling edge, check ready, advance the model at the rising edge, check outputs.
  task automatic applyStimulus(input bit rst, input bit v, input bit m, input bit f, input bit dr,
                               input logic [PPC*PW-1:0] cp, input logic [PPC*PW-1:0] rp);
    int sum;
    int c;
    int r;
    int res;
    @(negedge clk);
    reset         = rst;
    bus.src_valid = v;
    bus.mode      = m;
    bus.flush     = f;
    bus.dst_ready = dr;
    bus.curr_pix  = cp;
    bus.ref_pix   = rp;
    #1;
    exp_ready = !rst && !f && (!exp_valid || dr);
    checkVal("src_ready", {31'd0, bus.src_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (rst) begin
      model_rst = 1'b1;
      exp_valid = 1'b0;
      exp_first = 1'b0;
      exp_last  = 1'b0;
      exp_res   = '0;
      exp_sad   = 0;
      blk_beat  = 0;
      blk_sad   = 0;
      blk_mode  = 1'b0;
    end else begin
      model_rst = 1'b0;
      if (f) begin
        exp_valid = 1'b0;
        exp_sad   = 0;
        blk_beat  = 0;
        blk_sad   = 0;
        blk_mode  = 1'b0;
      end else if (v && exp_ready) begin
        if (blk_beat == 0) begin
          blk_mode = m;
          blk_sad  = 0;
        end
        sum = 0;
        for (int k = 0; k < PPC; k++) begin
          c   = int'(cp[k*PW +: PW]);
          r   = int'(rp[k*PW +: PW]);
          res = laneResidual(c, r, blk_mode);
          exp_res[k*RW +: RW] = RW'(res);
          sum += (res < 0) ? -res : res;
        end
        blk_sad  += sum;
        exp_first = (blk_beat == 0);
        exp_last  = (blk_beat == BEATS - 1);
        exp_sad   = blk_sad;
        exp_valid = 1'b1;
        blk_beat  = (blk_beat + 1) % BEATS;
      end else if (dr) begin
        exp_valid = 1'b0;
      end
    end
    #1;
    checkOutput();
  endtask

  initial begin
    bus.src_valid = 1'b0;
    bus.mode      = 1'b0;
    bus.flush     = 1'b0;
    bus.dst_ready = 1'b0;
    bus.curr_pix  = '0;
    bus.ref_pix   = '0;
    exp_valid = 1'b0;
    exp_res   = '0;
    $display("[TB] mc_residual_stream bench start");

    // Reset with a beat offered: nothing may be accepted and all outputs read zero.
    repeat (3) applyStimulus(1, 1, 1, 0, 1, fill(200), fill(50));

    // Constant inter block: +150 per lane.
    obs_last_sad = -1;
    for (int i = 0; i < BEATS; i++) applyStimulus(0, 1, 0, 0, 1, fill(200), fill(50));
    checkVal("sad_const_150", obs_last_sad, 9600);
    checkVal("res_const_150", 32'(obs_last_res), 32'({9'd150, 9'd150}));
    applyStimulus(0, 0, 0, 0, 1, '0, '0);

    // Most negative residual, no wrap.
    obs_last_sad = -1;
    for (int i = 0; i < BEATS; i++) applyStimulus(0, 1, 0, 0, 1, fill(0), fill(255));
    checkVal("sad_neg_255", obs_last_sad, 16320);
    checkVal("res_neg_255", 32'(obs_last_res), 32'({9'h101, 9'h101}));

    // Most positive residual, back-to-back with the previous block.
    obs_last_sad = -1;
    for (int i = 0; i < BEATS; i++) applyStimulus(0, 1, 0, 0, 1, fill(255), fill(0));
    checkVal("sad_pos_255", obs_last_sad, 16320);
    checkVal("res_pos_255", 32'(obs_last_res), 32'({9'd255, 9'd255}));
    applyStimulus(0, 0, 0, 0, 1, '0, '0);

    // Intra bypass latched on beat 0; later mode toggles and random refs must not matter.
    obs_last_sad = -1;
    for (int i = 0; i < BEATS; i++)
      applyStimulus(0, 1, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 0, 1, fill(128), randPix());
    checkVal("sad_intra_zero", obs_last_sad, 0);
    checkVal("res_intra_zero", 32'(obs_last_res), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, '0, '0);

    // Random traffic with random backpressure and random modes.
    for (int i = 0; i < 400; i++)
      applyStimulus(0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 0,
                    1'($urandom_range(0, 1)), randPix(), randPix());
    applyStimulus(0, 0, 0, 0, 1, '0, '0);

    // Flush realigns, then abort at beat 10 with a beat offered, then a clean block.
    applyStimulus(0, 0, 0, 1, 1, '0, '0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 1, randPix(), randPix());
    applyStimulus(0, 1, 0, 1, 1, randPix(), randPix());
    checkVal("valid_after_flush", {31'd0, bus.dst_valid}, 32'd0);
    obs_last_sad = -1;
    for (int i = 0; i < BEATS; i++) applyStimulus(0, 1, 0, 0, 1, fill(10), fill(3));
    checkVal("sad_after_flush", obs_last_sad, 448);
    applyStimulus(0, 0, 0, 0, 1, '0, '0);

    // Two blocks back to back at full rate: 64 consecutive valid cycles.
    valid_cycles = 0;
    for (int i = 0; i < 2 * BEATS; i++)
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0, 1, randPix(), randPix());
    applyStimulus(0, 0, 0, 0, 1, '0, '0);
    checkVal("b2b_valid_cycles", valid_cycles, 2 * BEATS);

    // Reset in the middle of a block discards it.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 1, randPix(), randPix());
    repeat (2) applyStimulus(1, 0, 0, 0, 1, '0, '0);
    obs_last_sad = -1;
    for (int i = 0; i < BEATS; i++) applyStimulus(0, 1, 0, 0, 1, fill(10), fill(3));
    checkVal("sad_after_reset", obs_last_sad, 448);
    applyStimulus(0, 0, 0, 0, 1, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
